// File: rtl/serial_alu_slice_pkg.sv
// Shared encodings for the bit-serial ALU slice: operation codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_alu_slice_pkg;

  // Operation select. Codes 5..7 all behave as PASS A.
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_PASS = 3'd5
  } alu_op_e;

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  // True for the ops that use the full-adder path and report a carry.
  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/serial_alu_slice_if.sv
// Request/result bundle between a requester and the bit-serial ALU slice.
// Latency: n/a (wires only).
// Backpressure: none; the requester watches busy, and a start seen while busy is dropped.
interface serial_alu_slice_if #(
  parameter int WIDTH = 32
);
  import serial_alu_slice_pkg::*;

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             cout;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, y, cout, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, y, cout, zero
  );

endinterface

// File: rtl/serial_fa_cell.sv
// One-bit full adder built only from NAND2 cells (9 gates), plus the NAND2 cell itself.
// Latency: combinational.
// Backpressure: n/a.
module nand2_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic n1, n2, n3, x1, n5, n6, n7;

  // First half adder: x1 = a ^ b, n1 = ~(a & b).
  nand2_cell u_g1 (.a(a),  .b(b),  .y(n1));
  nand2_cell u_g2 (.a(a),  .b(n1), .y(n2));
  nand2_cell u_g3 (.a(b),  .b(n1), .y(n3));
  nand2_cell u_g4 (.a(n2), .b(n3), .y(x1));
  // Second half adder: s = x1 ^ ci, n5 = ~(x1 & ci).
  nand2_cell u_g5 (.a(x1), .b(ci), .y(n5));
  nand2_cell u_g6 (.a(x1), .b(n5), .y(n6));
  nand2_cell u_g7 (.a(ci), .b(n5), .y(n7));
  nand2_cell u_g8 (.a(n6), .b(n7), .y(s));
  // Carry out: (a & b) | (x1 & ci).
  nand2_cell u_g9 (.a(n1), .b(n5), .y(co));

endmodule

// File: rtl/serial_alu_slice.sv
// Bit-serial ALU: ADD/SUB/AND/OR/XOR/PASS on WIDTH-bit operands, one bit per clock, LSB first.
// Latency: WIDTH+1 cycles from accepted start to the done pulse; one result per WIDTH+2 cycles.
// Backpressure: busy high in RUN/DONE; start is only sampled in IDLE, otherwise dropped.
module serial_alu_slice #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  serial_alu_slice_if.slave  bus
);
  import serial_alu_slice_pkg::*;

  alu_state_e       state;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] srb;
  logic [WIDTH-1:0] res;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             zacc;

  logic             a0;
  logic             b0;
  logic             fa_s;
  logic             fa_co;
  logic             s_bit;
  logic             arith;
  logic             cnt_last;
  logic [WIDTH-1:0] res_next;
  logic             zacc_next;

  // SUB is A + ~B + 1: B is inverted here and the carry is preloaded with 1 on accept.
  assign a0        = sra[0];
  assign b0        = srb[0] ^ (op_q == ALU_SUB);
  assign arith     = op_is_arith(op_q);
  assign cnt_last  = (cnt == CNT_W'(WIDTH - 1));
  assign res_next  = {s_bit, res[WIDTH-1:1]};
  assign zacc_next = zacc & ~s_bit;

  serial_fa_cell u_fa (
    .a  (a0),
    .b  (b0),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // Result bit for the current position, selected by the latched op.
  always_comb begin
    s_bit = a0;
    case (op_q)
      ALU_ADD, ALU_SUB: s_bit = fa_s;
      ALU_AND:          s_bit = a0 & b0;
      ALU_OR:           s_bit = a0 | b0;
      ALU_XOR:          s_bit = a0 ^ b0;
      default:          s_bit = a0;
    endcase
  end

  // Control FSM with operand shifters, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sra       <= '0;
      srb       <= '0;
      res       <= '0;
      op_q      <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      zacc      <= 1'b1;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.y     <= '0;
      bus.cout  <= 1'b0;
      bus.zero  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            sra      <= bus.a;
            srb      <= bus.b;
            op_q     <= bus.op;
            cnt      <= '0;
            carry    <= (bus.op == ALU_SUB);
            zacc     <= 1'b1;
            bus.busy <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sra  <= sra >> 1;
          srb  <= srb >> 1;
          res  <= res_next;
          zacc <= zacc_next;
          cnt  <= cnt + CNT_W'(1);
          if (arith) begin
            carry <= fa_co;
          end
          // Last bit: publish the fully shifted result, including this cycle's bit.
          if (cnt_last) begin
            bus.y    <= res_next;
            bus.zero <= zacc_next;
            bus.cout <= arith ? fa_co : 1'b0;
            bus.done <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_slice.sv
// Directed bench for serial_alu_slice: reset state, each op, carry/borrow edges, ignored start, mid-run reset.
// Latency: checks done arrives exactly WIDTH+1 cycles after the accepting edge.
// Backpressure: drives start only in idle except where a dropped start is intended.
module tb_serial_alu_slice;
  import serial_alu_slice_pkg::*;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  serial_alu_slice_if #(.WIDTH(WIDTH)) bus ();

  serial_alu_slice #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op in idle, wait for done (bounded), then check latency and results.
  task automatic run_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ey, input logic ec,
                         input logic ez);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = 32'hDEAD_BEEF;
    bus.b     = 32'h5555_AAAA;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    end while (!bus.done && cyc < 100);
    check({tag, "_lat"},  cyc,           LAT);
    check({tag, "_y"},    bus.y,         ey);
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    check({tag, "_zero"}, 32'(bus.zero), 32'(ez));
  endtask

  initial begin
    int dones;
    n_chk  = 0;
    n_pass = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_y",    bus.y,         32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    rst = 1'b0;

    run_vec("add_3_5",    3'd0, 32'd3,          32'd5,          32'd8,          1'b0, 1'b0);
    run_vec("add_wrap",   3'd0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1);
    run_vec("add_chain",  3'd0, 32'h0000_FFFF,  32'd1,          32'h0001_0000,  1'b0, 1'b0);
    run_vec("sub_5_7",    3'd1, 32'd5,          32'd7,          32'hFFFF_FFFE,  1'b0, 1'b0);
    run_vec("sub_7_7",    3'd1, 32'd7,          32'd7,          32'd0,          1'b1, 1'b1);
    run_vec("and",        3'd2, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0);
    run_vec("or",         3'd3, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0,  1'b0, 1'b0);
    run_vec("xor",        3'd4, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  1'b0, 1'b0);
    run_vec("pass6",      3'd6, 32'h1234_5678,  32'hFFFF_FFFF,  32'h1234_5678,  1'b0, 1'b0);
    run_vec("pass7",      3'd7, 32'h8000_0001,  32'h0000_0000,  32'h8000_0001,  1'b0, 1'b0);

    // A start raised mid-run must be dropped: one done, result of the first op.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    dones = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
      if (i == 5) begin
        bus.start = 1'b1;
        bus.a     = 32'd1;
        bus.b     = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
    end
    check("ign_dones", dones, 32'd1);
    check("ign_y",     bus.y, 32'd8);

    // Reset at cycle 10 of a run: abort, outputs back to reset values, no done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = 32'd3;
    bus.b     = 32'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_y",    bus.y,         32'd0);
    check("mrst_zero", 32'(bus.zero), 32'd1);
    check("mrst_done", 32'(bus.done), 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mrst_nodone", dones, 32'd0);
    run_vec("add_2_2", 3'd0, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
